// File: rtl/cache_refill_ctrl.sv
// Miss handler: picks a victim way, writes back a dirty victim, burst-refills the line and commits it.
// Optional `REFILL_STAT_EN adds saturating stat_miss_o / stat_wb_o counters.
module cache_refill_ctrl #(
    parameter int SET_ASSOC  = 4,
    parameter int LINE_WORDS = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic [ADDR_WIDTH-1:0]               req_addr_i,
    input  logic [SET_ASSOC-1:0]                set_valid_i,
    input  logic [SET_ASSOC-1:0]                set_dirty_i,
    input  logic [$clog2(SET_ASSOC)-1:0]        repl_index_i,
    input  logic [SET_ASSOC*ADDR_WIDTH-1:0]     victim_addr_i,
    input  logic [SET_ASSOC*LINE_WORDS*32-1:0]  victim_data_i,
    input  logic                                hit_valid_i,
    input  logic [SET_ASSOC-1:0]                hit_way_i,
    output logic [SET_ASSOC-1:0]                plru_access_o,
    output logic                                plru_update_o,
    output logic                                mem_wvalid_o,
    input  logic                                mem_wready_i,
    output logic [ADDR_WIDTH-1:0]               mem_waddr_o,
    output logic [31:0]                         mem_wdata_o,
    output logic                                mem_wlast_o,
    output logic                                mem_arvalid_o,
    input  logic                                mem_arready_i,
    output logic [ADDR_WIDTH-1:0]               mem_araddr_o,
    input  logic                                mem_rvalid_i,
    input  logic [31:0]                         mem_rdata_i,
    output logic                                fill_valid_o,
    output logic [$clog2(SET_ASSOC)-1:0]        fill_way_o,
    output logic [ADDR_WIDTH-1:0]               fill_addr_o,
    output logic [LINE_WORDS*32-1:0]            fill_data_o
`ifdef REFILL_STAT_EN
    ,
    output logic [31:0]                         stat_miss_o,
    output logic [31:0]                         stat_wb_o
`endif
);
    localparam int WAY_W  = $clog2(SET_ASSOC);
    localparam int CNT_W  = $clog2(LINE_WORDS);
    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int LINE_W = LINE_WORDS * 32;
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH - OFF_W){1'b1}}, {OFF_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, WB, RD_REQ, RD_DATA, FILL} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [WAY_W-1:0]    victim_q;
    logic [WAY_W-1:0]    victim_sel;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [LINE_W-1:0]   line_q;
    logic                found;
    logic                sel_dirty;
    logic                accept;

    // Lowest invalid way wins; only a fully valid set falls back to the PLRU choice.
    always_comb begin
        victim_sel = repl_index_i;
        found      = 1'b0;
        for (int i = 0; i < SET_ASSOC; i++) begin
            if (!set_valid_i[i] && !found) begin
                victim_sel = WAY_W'(i);
                found      = 1'b1;
            end
        end
    end

    assign sel_dirty = set_valid_i[victim_sel] & set_dirty_i[victim_sel];
    assign accept    = req_valid_i & req_ready_o;

    always_comb begin
        state_d       = state_q;
        req_ready_o   = 1'b0;
        mem_wvalid_o  = 1'b0;
        mem_arvalid_o = 1'b0;
        fill_valid_o  = 1'b0;
        plru_access_o = '0;
        plru_update_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = sel_dirty ? WB : RD_REQ;
            end
            WB: begin
                mem_wvalid_o = 1'b1;
                if (mem_wready_i && cnt_q == LAST_BEAT) state_d = RD_REQ;
            end
            RD_REQ: begin
                mem_arvalid_o = 1'b1;
                if (mem_arready_i) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (mem_rvalid_i && cnt_q == LAST_BEAT) state_d = FILL;
            end
            FILL: begin
                fill_valid_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // The refill's MRU update takes precedence over a hit in the same cycle.
        if (state_q == FILL) begin
            plru_access_o = {{(SET_ASSOC - 1){1'b0}}, 1'b1} << victim_q;
            plru_update_o = 1'b1;
        end else if (hit_valid_i) begin
            plru_access_o = hit_way_i;
            plru_update_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // One line buffer serves both directions: the victim drains out before refill words land.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            victim_q <= '0;
            addr_q   <= '0;
            waddr_q  <= '0;
            line_q   <= '0;
        end else begin
            if (accept) begin
                victim_q <= victim_sel;
                addr_q   <= req_addr_i & LINE_MASK;
                waddr_q  <= victim_addr_i[victim_sel * ADDR_WIDTH +: ADDR_WIDTH];
                line_q   <= victim_data_i[victim_sel * LINE_W +: LINE_W];
                cnt_q    <= '0;
            end
            if (state_q == WB && mem_wready_i) cnt_q <= cnt_q + 1'b1;
            if (state_q == RD_DATA && mem_rvalid_i) begin
                line_q[cnt_q * 32 +: 32] <= mem_rdata_i;
                cnt_q                    <= cnt_q + 1'b1;
            end
        end
    end

    assign mem_waddr_o  = waddr_q;
    assign mem_wdata_o  = line_q[cnt_q * 32 +: 32];
    assign mem_wlast_o  = (state_q == WB) && (cnt_q == LAST_BEAT);
    assign mem_araddr_o = addr_q;
    assign fill_way_o   = victim_q;
    assign fill_addr_o  = addr_q;
    assign fill_data_o  = line_q;

`ifdef REFILL_STAT_EN
    logic [31:0] stat_miss_q;
    logic [31:0] stat_wb_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_miss_q <= '0;
            stat_wb_q   <= '0;
        end else begin
            if (accept && stat_miss_q != 32'hFFFF_FFFF) stat_miss_q <= stat_miss_q + 32'd1;
            if (accept && sel_dirty && stat_wb_q != 32'hFFFF_FFFF) stat_wb_q <= stat_wb_q + 32'd1;
        end
    end

    assign stat_miss_o = stat_miss_q;
    assign stat_wb_o   = stat_wb_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: directed misses against a small memory model.
// Build with +define+REFILL_STAT_EN to also check the statistics counters.
`timescale 1ns/1ps
module tb_cache_refill_ctrl;
    localparam int SA     = 4;
    localparam int LW     = 8;
    localparam int AW     = 32;
    localparam int LINE_W = LW * 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              reqValid = 1'b0;
    logic              reqReady;
    logic [AW-1:0]     reqAddr = '0;
    logic [SA-1:0]     setValid = '0;
    logic [SA-1:0]     setDirty = '0;
    logic [1:0]        replIndex = '0;
    logic [SA*AW-1:0]  victimAddr = '0;
    logic [SA*LINE_W-1:0] victimData = '0;
    logic              hitValid = 1'b0;
    logic [SA-1:0]     hitWay = '0;
    logic [SA-1:0]     plruAccess;
    logic              plruUpdate;
    logic              memWvalid;
    logic              memWready;
    logic [AW-1:0]     memWaddr;
    logic [31:0]       memWdata;
    logic              memWlast;
    logic              memArvalid;
    logic              memArready;
    logic [AW-1:0]     memAraddr;
    logic              memRvalid;
    logic [31:0]       memRdata;
    logic              fillValid;
    logic [1:0]        fillWay;
    logic [AW-1:0]     fillAddr;
    logic [LINE_W-1:0] fillData;
`ifdef REFILL_STAT_EN
    logic [31:0]       statMiss;
    logic [31:0]       statWb;
`endif

    cache_refill_ctrl #(.SET_ASSOC(SA), .LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(reqValid), .req_ready_o(reqReady), .req_addr_i(reqAddr),
        .set_valid_i(setValid), .set_dirty_i(setDirty), .repl_index_i(replIndex),
        .victim_addr_i(victimAddr), .victim_data_i(victimData),
        .hit_valid_i(hitValid), .hit_way_i(hitWay),
        .plru_access_o(plruAccess), .plru_update_o(plruUpdate),
        .mem_wvalid_o(memWvalid), .mem_wready_i(memWready), .mem_waddr_o(memWaddr),
        .mem_wdata_o(memWdata), .mem_wlast_o(memWlast),
        .mem_arvalid_o(memArvalid), .mem_arready_i(memArready), .mem_araddr_o(memAraddr),
        .mem_rvalid_i(memRvalid), .mem_rdata_i(memRdata),
        .fill_valid_o(fillValid), .fill_way_o(fillWay), .fill_addr_o(fillAddr),
        .fill_data_o(fillData)
`ifdef REFILL_STAT_EN
        , .stat_miss_o(statMiss), .stat_wb_o(statWb)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]        way;
        logic [31:0]       addr;
        logic [LINE_W-1:0] data;
        int                accCycle;
        int                latency;
    } fillExp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } wbExp_t;

    fillExp_t          fillQ[$];
    wbExp_t            wbQ[$];
    logic [31:0]       arQ[$];
    logic [3:0]        plruQ[$];
    logic [LINE_W-1:0] memLineQ[$];

    int   totalChecks = 0;
    int   badChecks   = 0;
    int   cycleCnt    = 0;
    int   expMiss     = 0;
    int   expWb       = 0;
    logic bpMode      = 1'b0;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                               input logic [LINE_W-1:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] vAddr(input int w);
        return 32'h8000_0000 + 32'(w) * 32'h100;
    endfunction

    function automatic logic [LINE_W-1:0] makeLine(input logic [31:0] base);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LW; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    task automatic gotoCycle(input int n);
        while (cycleCnt < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Memory model: handshakes are sampled mid-cycle, responses driven just after the edge.
    initial begin
        int   beatsLeft;
        int   beatIdx;
        int   gapCnt;
        logic arFire;
        logic rFire;
        logic rstSeen;
        logic [LINE_W-1:0] curLine;
        beatsLeft  = 0;
        beatIdx    = 0;
        gapCnt     = 0;
        curLine    = '0;
        memWready  = 1'b1;
        memArready = 1'b1;
        memRvalid  = 1'b0;
        memRdata   = '0;
        forever begin
            @(negedge clk);
            arFire  = memArvalid && memArready;
            rFire   = memRvalid;
            rstSeen = rst;
            @(posedge clk);
            #1;
            memWready  = bpMode ? ~memWready : 1'b1;
            memArready = bpMode ? ~memArready : 1'b1;
            if (rstSeen) begin
                beatsLeft = 0;
                memRvalid = 1'b0;
                continue;
            end
            if (rFire && beatsLeft > 0) begin
                beatsLeft--;
                beatIdx++;
            end
            if (arFire) begin
                curLine   = (memLineQ.size() != 0) ? memLineQ.pop_front() : '0;
                beatsLeft = LW;
                beatIdx   = 0;
            end
            gapCnt++;
            if (beatsLeft > 0 && (!bpMode || (gapCnt % 3) != 1)) begin
                memRvalid = 1'b1;
                memRdata  = curLine[beatIdx*32 +: 32];
            end else begin
                memRvalid = 1'b0;
            end
        end
    end

    // Monitor: every presented output event pops and compares the oldest expectation.
    fillExp_t fe;
    wbExp_t   we;
    always @(negedge clk) begin
        if (!rst) begin
            if (fillValid) begin
                checkOutput("fill expected", fillQ.size() != 0, 1'b1);
                if (fillQ.size() != 0) begin
                    fe = fillQ.pop_front();
                    checkOutput("fill_way", fillWay, fe.way);
                    checkOutput("fill_addr", fillAddr, fe.addr);
                    checkOutput("fill_data", fillData, fe.data);
                    if (fe.latency >= 0) checkOutput("fill latency", cycleCnt - fe.accCycle, fe.latency);
                end
            end
            if (plruUpdate) begin
                checkOutput("plru expected", plruQ.size() != 0, 1'b1);
                if (plruQ.size() != 0) checkOutput("plru_access", plruAccess, plruQ.pop_front());
            end
            if (memWvalid && memWready) begin
                checkOutput("wbeat expected", wbQ.size() != 0, 1'b1);
                if (wbQ.size() != 0) begin
                    we = wbQ.pop_front();
                    checkOutput("mem_waddr", memWaddr, we.addr);
                    checkOutput("mem_wdata", memWdata, we.data);
                    checkOutput("mem_wlast", memWlast, we.last);
                end
            end
            if (memArvalid && memArready) begin
                checkOutput("ar expected", arQ.size() != 0, 1'b1);
                if (arQ.size() != 0) checkOutput("mem_araddr", memAraddr, arQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] expAddr,
                                 input logic [3:0] valid, input logic [3:0] dirty,
                                 input logic [1:0] repl, input int expWay, input bit expWbFlag,
                                 input logic [31:0] lineBase, input int latency,
                                 input bit doFill, output int accCycle);
        fillExp_t f;
        if (expWbFlag)
            for (int k = 0; k < LW; k++)
                wbQ.push_back('{addr: vAddr(expWay), data: 32'(expWay * 16 + k), last: (k == LW - 1)});
        arQ.push_back(expAddr);
        memLineQ.push_back(makeLine(lineBase));
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (reqReady) break;
        end
        checkOutput("req_ready before request", reqReady, 1'b1);
        @(posedge clk);
        #1;
        reqValid  = 1'b1;
        reqAddr   = addr;
        setValid  = valid;
        setDirty  = dirty;
        replIndex = repl;
        accCycle  = cycleCnt;
        expMiss++;
        if (expWbFlag) expWb++;
        if (doFill) begin
            f.way      = 2'(expWay);
            f.addr     = expAddr;
            f.data     = makeLine(lineBase);
            f.accCycle = accCycle;
            f.latency  = latency;
            fillQ.push_back(f);
            plruQ.push_back(4'b0001 << expWay);
        end
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (fillQ.size() + wbQ.size() + arQ.size() + plruQ.size() == 0 && reqReady) break;
        end
        checkOutput("queues drained", fillQ.size() + wbQ.size() + arQ.size() + plruQ.size(), 0);
    endtask

    initial begin
        int acc;
        for (int w = 0; w < SA; w++) begin
            victimAddr[w*AW +: AW] = vAddr(w);
            for (int k = 0; k < LW; k++) victimData[(w*LW + k)*32 +: 32] = 32'(w * 16 + k);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset req_ready", reqReady, 1'b1);
        checkOutput("reset fill_valid", fillValid, 1'b0);
        checkOutput("reset mem_wvalid", memWvalid, 1'b0);
        checkOutput("reset mem_arvalid", memArvalid, 1'b0);
        checkOutput("reset plru_update", plruUpdate, 1'b0);
        checkOutput("reset fill_data", fillData, '0);
        checkOutput("reset fill_addr", fillAddr, '0);

        $display("[TB] invalid-way preference");
        applyStimulus(32'h0000_1234, 32'h0000_1220, 4'b1011, 4'b0000, 2'd3, 2, 0,
                      32'hA000_0000, 10, 1, acc);
        waitDrain();

        $display("[TB] reset during read burst");
        applyStimulus(32'h0000_C000, 32'h0000_C000, 4'b1110, 4'b0000, 2'd3, 0, 0,
                      32'hC000_0000, -1, 0, acc);
        gotoCycle(acc + 5);
        rst     = 1'b1;
        expMiss = 0;
        expWb   = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset req_ready", reqReady, 1'b1);
        checkOutput("post-reset fill_valid", fillValid, 1'b0);
        repeat (12) @(negedge clk);
        applyStimulus(32'h0000_D010, 32'h0000_D000, 4'b1111, 4'b0000, 2'd2, 2, 0,
                      32'hD000_0000, 10, 1, acc);
        waitDrain();

        $display("[TB] dirty victim write-back");
        applyStimulus(32'h0000_4000, 32'h0000_4000, 4'b1111, 4'b0010, 2'd1, 1, 1,
                      32'h4000_0000, 18, 1, acc);
        waitDrain();

        $display("[TB] dirty but invalid way needs no write-back");
        applyStimulus(32'h2000_005C, 32'h2000_0040, 4'b0111, 4'b1111, 2'd0, 3, 0,
                      32'h2000_0000, 10, 1, acc);
        waitDrain();

        $display("[TB] backpressure");
        bpMode = 1'b1;
        applyStimulus(32'h0000_8047, 32'h0000_8040, 4'b1111, 4'b1000, 2'd3, 3, 1,
                      32'hB000_0000, -1, 1, acc);
        waitDrain();
        bpMode = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] hit during fill and hit in idle");
        applyStimulus(32'h0000_6000, 32'h0000_6000, 4'b0111, 4'b0000, 2'd0, 3, 0,
                      32'h6000_0000, 10, 1, acc);
        gotoCycle(acc + 10);
        hitValid = 1'b1;
        hitWay   = 4'b0001;
        @(posedge clk);
        #1;
        hitValid = 1'b0;
        gotoCycle(acc + 12);
        plruQ.push_back(4'b0001);
        hitValid = 1'b1;
        hitWay   = 4'b0001;
        @(posedge clk);
        #1;
        hitValid = 1'b0;
        waitDrain();

`ifdef REFILL_STAT_EN
        checkOutput("stat_miss", statMiss, 32'(expMiss));
        checkOutput("stat_wb", statWb, 32'(expWb));
`endif
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
